// File: rtl/cc_bus_pkg.sv
// Shared types and constants for the ChronoCube MCU bus bridge (cc_bus_sync).
package cc_bus_pkg;

  localparam int unsigned CC_ADDR_WIDTH_DEF  = 8;
  localparam int unsigned CC_DATA_WIDTH_DEF  = 8;
  localparam int unsigned CC_SYNC_STAGES_DEF = 2;

  localparam int unsigned               ERR_CNT_WIDTH = 8;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_DRIVE     = 3'd4,
    ST_HOLD      = 3'd5
  } cc_state_e;

  function automatic logic [ERR_CNT_WIDTH-1:0] err_cnt_inc(input logic [ERR_CNT_WIDTH-1:0] cnt);
    if (cnt == ERR_CNT_MAX) begin
      return cnt;
    end else begin
      return cnt + 8'd1;
    end
  endfunction

endpackage

// File: rtl/cc_sync_chain.sv
// Multi-flop synchronizer for a group of asynchronous inputs; RST_VAL sets the
// idle level (1 for active-low strobes/select, 0 for address/data).
module cc_sync_chain #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  // Shift the raw input in at stage 0; the oldest sample leaves at the top.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= {(STAGES*WIDTH){RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/cc_bus_sync.sv
// Slave bridge from the asynchronous MCU parallel bus to the internal register space.
// Optional feature: define CC_BUS_SYNC_ERR_COUNT_EN to build the saturating error counter.
module cc_bus_sync
  import cc_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = CC_ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH  = CC_DATA_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = CC_SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mcu_nsel,
  input  logic                     mcu_nrd,
  input  logic                     mcu_nwr,
  input  logic [ADDR_WIDTH-1:0]    mcu_addr,
  input  logic [DATA_WIDTH-1:0]    pin_data_in,
  output logic [DATA_WIDTH-1:0]    pin_data_out,
  output logic                     pin_sel_in,
  output logic [ADDR_WIDTH-1:0]    reg_addr,
  output logic [DATA_WIDTH-1:0]    reg_wr_data,
  output logic                     reg_wr,
  output logic                     reg_rd,
  input  logic [DATA_WIDTH-1:0]    reg_rd_data,
  input  logic                     reg_rd_valid,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  logic [2:0]            ctrl_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic nsel_s, nrd_s, nwr_s;
  logic wr_act_s, rd_act_s, conflict_s, released_s, err_evt_s;

  cc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
  logic [DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;
  logic [DATA_WIDTH-1:0] pin_data_out_q, pin_data_out_d;
  logic reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, pin_sel_q, pin_sel_d;

  cc_sync_chain #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ctrl (
    .clk(clk), .reset(reset), .d({mcu_nsel, mcu_nrd, mcu_nwr}), .q(ctrl_s)
  );
  cc_sync_chain #(.WIDTH(ADDR_WIDTH), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_addr (
    .clk(clk), .reset(reset), .d(mcu_addr), .q(addr_s)
  );
  cc_sync_chain #(.WIDTH(DATA_WIDTH), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk(clk), .reset(reset), .d(pin_data_in), .q(data_s)
  );

  assign {nsel_s, nrd_s, nwr_s} = ctrl_s;
  assign wr_act_s   = ~nsel_s & ~nwr_s & nrd_s;
  assign rd_act_s   = ~nsel_s & ~nrd_s & nwr_s;
  assign conflict_s = ~nsel_s & ~nrd_s & ~nwr_s;
  assign released_s = nsel_s | (nrd_s & nwr_s);

  // Transaction FSM: next state, captured address/data and error events.
  always_comb begin
    state_d       = state_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    rd_buf_d      = rd_buf_q;
    err_evt_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_act_s) begin
          state_d       = ST_WRITE;
          reg_addr_d    = addr_s;
          reg_wr_data_d = data_s;
        end else if (rd_act_s) begin
          state_d    = ST_READ_REQ;
          reg_addr_d = addr_s;
        end else if (conflict_s) begin
          state_d   = ST_HOLD;
          err_evt_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE:    state_d = ST_HOLD;
      ST_READ_REQ: state_d = ST_READ_WAIT;
      ST_READ_WAIT: begin
        // Losing the strobe before data returns aborts; late data is then ignored in IDLE.
        if (!rd_act_s) begin
          state_d   = ST_IDLE;
          err_evt_s = 1'b1;
        end else if (reg_rd_valid) begin
          state_d  = ST_DRIVE;
          rd_buf_d = reg_rd_data;
        end else begin
          state_d = ST_READ_WAIT;
        end
      end
      ST_DRIVE: begin
        if (!rd_act_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_HOLD: begin
        if (released_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the current state, one cycle behind it.
  always_comb begin
    reg_wr_d  = (state_q == ST_WRITE);
    reg_rd_d  = (state_q == ST_READ_REQ);
    pin_sel_d = (state_q != ST_DRIVE);
    if (state_q == ST_DRIVE) begin
      pin_data_out_d = rd_buf_q;
    end else begin
      pin_data_out_d = pin_data_out_q;
    end
  end

  // State and output registers; reset releases the pins immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      reg_addr_q     <= {ADDR_WIDTH{1'b0}};
      reg_wr_data_q  <= {DATA_WIDTH{1'b0}};
      rd_buf_q       <= {DATA_WIDTH{1'b0}};
      pin_data_out_q <= {DATA_WIDTH{1'b0}};
      reg_wr_q       <= 1'b0;
      reg_rd_q       <= 1'b0;
      pin_sel_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      reg_addr_q     <= reg_addr_d;
      reg_wr_data_q  <= reg_wr_data_d;
      rd_buf_q       <= rd_buf_d;
      pin_data_out_q <= pin_data_out_d;
      reg_wr_q       <= reg_wr_d;
      reg_rd_q       <= reg_rd_d;
      pin_sel_q      <= pin_sel_d;
    end
  end

  assign reg_addr     = reg_addr_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign reg_wr       = reg_wr_q;
  assign reg_rd       = reg_rd_q;
  assign pin_sel_in   = pin_sel_q;
  assign pin_data_out = pin_data_out_q;

`ifdef CC_BUS_SYNC_ERR_COUNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  // Saturating count of conflict and aborted-read events.
  always_comb begin
    if (err_evt_s) begin
      err_count_d = err_cnt_inc(err_count_q);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  logic unused_err_evt_s;
  assign unused_err_evt_s = err_evt_s;
  assign err_count        = {ERR_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_cc_bus_sync.sv
// Randomized bench for cc_bus_sync: a cycle-indexed timeline model predicts every output.
module tb_cc_bus_sync;
  localparam int MAXC = 16384;
`ifdef CC_BUS_SYNC_ERR_COUNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, mcu_nsel, mcu_nrd, mcu_nwr, pin_sel_in, reg_wr, reg_rd, reg_rd_valid;
  logic [7:0] mcu_addr, pin_data_in, pin_data_out, reg_addr, reg_wr_data, reg_rd_data, err_count;

  int n_assert = 0, n_fail = 0, cyc = 0, err_model = 0;
  int wr_pulses = 0, rd_pulses = 0, last_wr_cyc = 0, last_rd_cyc = 0;
  bit chk_en = 1'b0;
  logic [7:0] last_wr_addr, last_wr_data;
  bit         exp_wr[MAXC], exp_rd[MAXC], exp_sel[MAXC], exp_err_chk[MAXC];
  logic [7:0] exp_addr[MAXC], exp_wdata[MAXC], exp_pdo[MAXC], exp_err_val[MAXC];

  cc_bus_sync dut (
    .clk(clk), .reset(reset), .mcu_nsel(mcu_nsel), .mcu_nrd(mcu_nrd), .mcu_nwr(mcu_nwr),
    .mcu_addr(mcu_addr), .pin_data_in(pin_data_in), .pin_data_out(pin_data_out),
    .pin_sel_in(pin_sel_in), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rd_data(reg_rd_data),
    .reg_rd_valid(reg_rd_valid), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] err_exp(input int n);
    if (!ERR_ON) return 8'd0;
    else if (n > 255) return 8'd255;
    else return n[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the timeline model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("reg_wr", reg_wr, exp_wr[cyc]);
      check("reg_rd", reg_rd, exp_rd[cyc]);
      check("pin_sel_in", pin_sel_in, exp_sel[cyc]);
      check("pin_data_out", pin_data_out, exp_pdo[cyc]);
      if (exp_wr[cyc]) begin
        check("wr_addr", reg_addr, exp_addr[cyc]);
        check("wr_data", reg_wr_data, exp_wdata[cyc]);
      end
      if (exp_rd[cyc]) check("rd_addr", reg_addr, exp_addr[cyc]);
      if (exp_err_chk[cyc]) check("err_count", err_count, exp_err_val[cyc]);
    end
    if (reg_wr === 1'b1) begin
      wr_pulses++; last_wr_cyc = cyc; last_wr_addr = reg_addr; last_wr_data = reg_wr_data;
    end
    if (reg_rd === 1'b1) begin
      rd_pulses++; last_rd_cyc = cyc;
    end
  end

  task automatic bus_idle();
    mcu_nsel = 1'b1; mcu_nrd = 1'b1; mcu_nwr = 1'b1;
    mcu_addr = 8'($urandom); pin_data_in = 8'($urandom);
  endtask

  task automatic mark_err_point();
    exp_err_chk[cyc] = 1'b1;
    exp_err_val[cyc] = err_exp(err_model);
  endtask

  // Strobe first sampled at edge e0; the write strobe is high in cycle e0+3.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold, input int gap,
                          output int e0);
    @(posedge clk); #1;
    mark_err_point();
    e0 = cyc + 1;
    mcu_nsel = 1'b0; mcu_nwr = 1'b0; mcu_nrd = 1'b1; mcu_addr = a; pin_data_in = d;
    exp_wr[e0+3] = 1'b1; exp_addr[e0+3] = a; exp_wdata[e0+3] = d;
    repeat (hold - 1) begin
      @(posedge clk); #1;
      reg_rd_valid = 1'($urandom_range(0, 1)); reg_rd_data = 8'($urandom);
    end
    @(posedge clk); #1;
    bus_idle(); reg_rd_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Valid sampled at k = e0+4+d; release first sampled at p; pins driven in [k+1, p+3).
  task automatic do_read(input logic [7:0] a, input logic [7:0] rdata, input int d, input int extra,
                         input int gap, output int e0);
    int k, p;
    @(posedge clk); #1;
    mark_err_point();
    e0 = cyc + 1;
    mcu_nsel = 1'b0; mcu_nrd = 1'b0; mcu_nwr = 1'b1; mcu_addr = a; pin_data_in = 8'($urandom);
    exp_rd[e0+3] = 1'b1; exp_addr[e0+3] = a;
    k = e0 + 4 + d;
    p = e0 + 5 + d + extra;
    for (int c = k + 1; c < p + 3; c++) exp_sel[c] = 1'b0;
    for (int c = k + 1; c < MAXC; c++) exp_pdo[c] = rdata;
    repeat (4 + d) @(posedge clk);
    #1;
    reg_rd_valid = 1'b1; reg_rd_data = rdata;
    @(posedge clk); #1;
    reg_rd_valid = 1'b0; reg_rd_data = 8'($urandom);
    repeat (extra) @(posedge clk);
    #1;
    bus_idle();
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Strobe released before data: one read request, an error, and a late ignored valid.
  task automatic do_abort(input logic [7:0] a, input int len, input int x, input int gap,
                          output int e0);
    @(posedge clk); #1;
    mark_err_point();
    e0 = cyc + 1;
    mcu_nsel = 1'b0; mcu_nrd = 1'b0; mcu_nwr = 1'b1; mcu_addr = a;
    exp_rd[e0+3] = 1'b1; exp_addr[e0+3] = a;
    repeat (len) @(posedge clk);
    #1;
    bus_idle();
    err_model++;
    repeat (3 + x) @(posedge clk);
    #1;
    reg_rd_valid = 1'b1; reg_rd_data = 8'($urandom);
    @(posedge clk); #1;
    reg_rd_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic do_conflict(input int len, input int gap);
    @(posedge clk); #1;
    mark_err_point();
    mcu_nsel = 1'b0; mcu_nrd = 1'b0; mcu_nwr = 1'b0;
    err_model++;
    repeat (len) @(posedge clk);
    #1;
    bus_idle();
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Strobe activity with chip select high must do nothing.
  task automatic do_noise(input int len, input int gap);
    @(posedge clk); #1;
    mark_err_point();
    mcu_nsel = 1'b1; mcu_nrd = 1'($urandom_range(0, 1)); mcu_nwr = 1'($urandom_range(0, 1));
    repeat (len) @(posedge clk);
    #1;
    bus_idle();
    repeat (gap) @(posedge clk);
    #1;
  endtask

  initial begin
    int e, wr0, rd0, t, kind;
    for (int c = 0; c < MAXC; c++) begin
      exp_sel[c] = 1'b1; exp_pdo[c] = 8'h00;
    end
    reset = 1'b1; bus_idle(); reg_rd_valid = 1'b0; reg_rd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pin_sel", pin_sel_in, 1'b1);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_reg_rd", reg_rd, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_wr_data", reg_wr_data, 8'h00);
    check("rst_pdo", pin_data_out, 8'h00);
    check("rst_err", err_count, 8'h00);
    reset = 1'b0; chk_en = 1'b1;

    wr0 = wr_pulses;
    do_write(8'h12, 8'hA5, 6, 4, e);
    check("wr_once", wr_pulses - wr0, 1);
    check("wr_lit_addr", last_wr_addr, 8'h12);
    check("wr_lit_data", last_wr_data, 8'hA5);
    check("wr_latency", last_wr_cyc - e, 3);

    rd0 = rd_pulses;
    do_read(8'h34, 8'h5C, 2, 3, 4, e);
    check("rd_once", rd_pulses - rd0, 1);
    check("rd_latency", last_rd_cyc - e, 3);
    check("rd_lit_pdo", pin_data_out, 8'h5C);
    check("rd_released", pin_sel_in, 1'b1);

    do_abort(8'h56, 4, 2, 4, e);
    check("abort_err", err_count, ERR_ON ? 8'd1 : 8'd0);
    check("abort_pdo", pin_data_out, 8'h5C);

    wr0 = wr_pulses; rd0 = rd_pulses;
    do_conflict(8, 4);
    check("conf_err", err_count, ERR_ON ? 8'd2 : 8'd0);
    check("conf_no_wr", wr_pulses - wr0, 0);
    check("conf_no_rd", rd_pulses - rd0, 0);

    wr0 = wr_pulses;
    do_write(8'h20, 8'h3C, 50, 4, e);
    check("held_wr_once", wr_pulses - wr0, 1);
    wr0 = wr_pulses;
    do_write(8'h21, 8'h4D, 6, 4, e);
    do_write(8'h22, 8'h5E, 6, 4, e);
    check("b2b_two_wr", wr_pulses - wr0, 2);

    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: do_write(8'($urandom), 8'($urandom), $urandom_range(4, 10), $urandom_range(2, 6), e);
        2, 3: do_read(8'($urandom), 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(2, 6), e);
        4: begin
          if ($urandom_range(0, 1) == 1) do_abort(8'($urandom), $urandom_range(4, 7),
                                                  $urandom_range(0, 3), $urandom_range(2, 5), e);
          else do_conflict($urandom_range(4, 9), $urandom_range(2, 5));
        end
        default: do_noise($urandom_range(2, 8), $urandom_range(2, 5));
      endcase
    end
    @(posedge clk); #1;
    mark_err_point();

    for (int i = 0; i < 300; i++) do_conflict(4, 2);
    check("err_saturate", err_count, ERR_ON ? 8'd255 : 8'd0);

    chk_en = 1'b0;
    @(posedge clk); #1;
    mcu_nsel = 1'b0; mcu_nrd = 1'b0; mcu_nwr = 1'b1; mcu_addr = 8'h9A;
    repeat (4) @(posedge clk);
    #1;
    reg_rd_valid = 1'b1; reg_rd_data = 8'h77;
    @(posedge clk); #1;
    reg_rd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("drive_sel", pin_sel_in, 1'b0);
    check("drive_pdo", pin_data_out, 8'h77);
    #2 reset = 1'b1;
    #1;
    check("arst_pin_sel", pin_sel_in, 1'b1);
    check("arst_pdo", pin_data_out, 8'h00);
    check("arst_reg_addr", reg_addr, 8'h00);
    check("arst_wr_data", reg_wr_data, 8'h00);
    check("arst_reg_wr", reg_wr, 1'b0);
    check("arst_reg_rd", reg_rd, 1'b0);
    check("arst_err", err_count, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    t = cyc;
    rd0 = rd_pulses;
    for (int i = 0; i < 20 && rd_pulses == rd0; i++) @(posedge clk);
    check("post_rst_rd_seen", rd_pulses - rd0, 1);
    check("post_rst_rd_latency", last_rd_cyc - (t + 1), 3);
    bus_idle();
    repeat (6) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
